op_dispatcher: RTL
==================

Name: op_dispatcher

Overview:
- Central scheduler between the instruction decoder and the processor's op handlers (line, arc, dummy, ...).
- Accepts one decoded op at a time and routes it by op code to a handler.
- Sequences the handler's rdy/trigger/done handshake and reports completion.
- Guards every wait with a watchdog; illegal op codes and stalled handlers produce a sticky error.

Parameters:
- NUM_HANDLERS, 4, number of attached handlers; op code N selects handler N.
- OP_BITS, 4, width of op_code.
- TIMEOUT_CYCLES, 1048576, enabled cycles allowed in any wait state before error.
- COUNT_BITS, 16, width of op_count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (low = reset)
- clk_en  in  1  FSM, counters and watchdog advance only on clk edges with clk_en=1
- op_valid  in  1  decoder offers an op
- op_code  in  OP_BITS  handler select
- op_rdy  out  1  dispatcher can accept an op
- trigger  out  NUM_HANDLERS  one-hot start strobe to the selected handler
- handler_rdy  in  NUM_HANDLERS  per-handler ready
- handler_done  in  NUM_HANDLERS  per-handler done, level
- busy  out  1  op in flight
- done  out  1  one-enabled-cycle completion pulse
- active_idx  out  $clog2(NUM_HANDLERS)  index of the latched handler
- op_count  out  COUNT_BITS  completed-op counter
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 illegal op, 2 rdy timeout, 3 done timeout
- err_clr  in  1  clears error state

Behaviour:
- Reset (async, reset=0): state IDLE. trigger=0, done=0, busy=0, err=0, err_code=0, active_idx=0, op_count=0, watchdog=0. op_rdy=1 once reset releases.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- State changes occur only on clk edges with clk_en=1. With clk_en=0, all state and outputs hold, including trigger and done.
- IDLE:
  - op_rdy=1, busy=0.
  - Accept when op_valid=1 and clk_en=1: latch op_code.
  - If op_code >= NUM_HANDLERS: go to ERROR with err_code=1.
  - Otherwise: active_idx=op_code, go to WAIT_RDY, clear watchdog.
- WAIT_RDY:
  - busy=1, op_rdy=0.
  - If handler_rdy[active_idx]=1: go to TRIGGER.
  - Else if watchdog = TIMEOUT_CYCLES-1: go to ERROR with err_code=2.
  - Else increment watchdog.
- TRIGGER:
  - trigger[active_idx]=1, all other trigger bits 0, for exactly one enabled cycle.
  - Then go to WAIT_DONE and clear watchdog.
- WAIT_DONE:
  - handler_done[active_idx]=1: go to IDLE, done=1 for one enabled cycle, op_count increments (wraps to 0 at max).
  - Otherwise the same timeout rule applies, going to ERROR with err_code=3.
  - done/rdy from non-selected handlers are ignored.
- ERROR:
  - err=1, op_rdy=0, busy=0, trigger=0.
  - err_clr=1 on an enabled edge: go to IDLE, err=0, err_code=0. op_count is retained.
- Latency, from op accepted at enabled edge N with handler already ready:
  - trigger high between edges N+1 and N+2.
  - done asserted the enabled edge after handler_done is sampled.
  - op_rdy returns high in the same cycle as done.
- Simultaneous events:
  - op_valid during done cycle: accepted, since op_rdy=1 in IDLE.
  - err_clr and op_valid together in ERROR: only the clear takes effect; the op is not accepted.
  - handler_done already high when entering WAIT_DONE: completes on the first WAIT_DONE edge.
- Reset mid-operation: trigger drops immediately (async). The in-flight op is abandoned and not counted.

Test Plan:
- NUM_HANDLERS=4, op_code=2, handler_rdy=4'b0100, handler_done[2] raised 10 cycles after trigger -> trigger=4'b0100 for exactly one cycle; done pulses once; op_count=1; op_rdy back to 1.
- op_code=5 -> no trigger; err=1, err_code=1; op_rdy=0. err_clr=1 -> err=0, op_rdy=1, op_count unchanged.
- TIMEOUT_CYCLES=8, handler_rdy[1] held 0 -> ERROR with err_code=2 after 8 enabled cycles in WAIT_RDY. Repeat with rdy=1 and done held 0 -> err_code=3.
- clk_en toggling 1/0 every cycle during a full op -> trigger and done each last exactly 2 clk cycles; sequence otherwise identical.
- Assert reset=0 while in WAIT_DONE -> trigger/busy/done=0 asynchronously; op_count=0; after release op_rdy=1.
- Back-to-back ops 0,3,1 with op_valid held high and handlers instantly ready/done -> triggers 0001, 1000, 0010 in order; op_count=3; no stray done from non-selected handlers.

Source files
------------

// File: rtl/op_dispatcher.sv
// Routes one decoded op at a time to its handler, sequencing the handler's
// rdy/trigger/done handshake under a watchdog, with a sticky error state.
module op_dispatcher #(
  parameter int NUM_HANDLERS   = 4,
  parameter int OP_BITS        = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int COUNT_BITS     = 16,
  localparam int IDX_W         = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    op_valid,
  input  logic [OP_BITS-1:0]      op_code,
  output logic                    op_rdy,
  output logic [NUM_HANDLERS-1:0] trigger,
  input  logic [NUM_HANDLERS-1:0] handler_rdy,
  input  logic [NUM_HANDLERS-1:0] handler_done,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        active_idx,
  output logic [COUNT_BITS-1:0]   op_count,
  output logic                    err,
  output logic [1:0]              err_code,
  input  logic                    err_clr
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OP_BITS:0]   NUM_OPS = (OP_BITS + 1)'(NUM_HANDLERS);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RDY_TO  = 2'd2;
  localparam logic [1:0] ERR_DONE_TO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_TRIGGER,
    S_WAIT_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WD_W-1:0]       r_wd;
  logic [WD_W-1:0]       w_wd_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [1:0]            r_err_code;
  logic [1:0]            w_err_code_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic [COUNT_BITS-1:0] r_count;
  logic [COUNT_BITS-1:0] w_count_nxt;

  logic w_illegal;
  logic w_wd_expired;
  logic w_sel_rdy;
  logic w_sel_done;

  assign w_illegal    = ({1'b0, op_code} >= NUM_OPS);
  assign w_wd_expired = (r_wd == WD_LAST);
  // Only the latched handler's handshake lines are ever looked at.
  assign w_sel_rdy    = handler_rdy[r_idx];
  assign w_sel_done   = handler_done[r_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wd       <= '0;
      r_idx      <= '0;
      r_err_code <= ERR_NONE;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else if (clk_en) begin
      r_state    <= w_state_nxt;
      r_wd       <= w_wd_nxt;
      r_idx      <= w_idx_nxt;
      r_err_code <= w_err_code_nxt;
      r_done     <= w_done_nxt;
      r_count    <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wd_nxt       = r_wd;
    w_idx_nxt      = r_idx;
    w_err_code_nxt = r_err_code;
    w_done_nxt     = 1'b0;
    w_count_nxt    = r_count;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          if (w_illegal) begin
            w_state_nxt    = S_ERROR;
            w_err_code_nxt = ERR_ILLEGAL;
          end else begin
            w_state_nxt = S_WAIT_RDY;
            w_idx_nxt   = op_code[IDX_W-1:0];
            w_wd_nxt    = '0;
          end
        end
      end
      S_WAIT_RDY: begin
        if (w_sel_rdy) begin
          w_state_nxt = S_TRIGGER;
        end else if (w_wd_expired) begin
          w_state_nxt    = S_ERROR;
          w_err_code_nxt = ERR_RDY_TO;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      S_TRIGGER: begin
        w_state_nxt = S_WAIT_DONE;
        w_wd_nxt    = '0;
      end
      S_WAIT_DONE: begin
        if (w_sel_done) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_count_nxt = r_count + COUNT_BITS'(1);
        end else if (w_wd_expired) begin
          w_state_nxt    = S_ERROR;
          w_err_code_nxt = ERR_DONE_TO;
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      S_ERROR: begin
        // A clear wins over a simultaneous op; the op must be re-offered.
        if (err_clr) begin
          w_state_nxt    = S_IDLE;
          w_err_code_nxt = ERR_NONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign op_rdy     = (r_state == S_IDLE);
  assign busy       = (r_state == S_WAIT_RDY) || (r_state == S_TRIGGER) ||
                      (r_state == S_WAIT_DONE);
  assign trigger    = (r_state == S_TRIGGER) ? (NUM_HANDLERS'(1) << r_idx) : '0;
  assign err        = (r_state == S_ERROR);
  assign err_code   = r_err_code;
  assign done       = r_done;
  assign active_idx = r_idx;
  assign op_count   = r_count;

endmodule
